pio_edge_capture_in: RTL and testbench

//  Avalon-MM slave input port for the Nios SOPC: the read-side counterpart of the LED output PIO.

---
 rtl/pio_edge_capture_in_pkg.sv | 31 +++
 rtl/pio_edge_capture_in_debounce_bit.sv | 93 +++++++++
 rtl/pio_edge_capture_in.sv | 131 +++++++++++++
 tb/tb_pio_edge_capture_in.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_edge_capture_in_pkg.sv
// ---------------------------------------------------------------------------
// pio_edge_capture_in_pkg
//
// Purpose:
//    Shared SOPC definitions for the input PIO: the Avalon word addresses of
//    the register map and the encodings for which input edge gets captured.
//
// Contents:
//    pio_addr_e    2-bit register word addresses (DATA, reserved, IRQMASK,
//                  EDGECAPTURE)
//    pio_edge_e    edge selection codes (rising, falling, any)
//    PIO_BUS_BITS  width of the Avalon data bus
// ---------------------------------------------------------------------------
package pio_edge_capture_in_pkg;

    typedef enum logic [1:0] {
        PIO_ADDR_DATA    = 2'd0,
        PIO_ADDR_RSVD    = 2'd1,
        PIO_ADDR_IRQMASK = 2'd2,
        PIO_ADDR_EDGECAP = 2'd3
    } pio_addr_e;

    typedef enum int {
        EDGE_RISING  = 0,
        EDGE_FALLING = 1,
        EDGE_ANY     = 2
    } pio_edge_e;

    localparam int PIO_BUS_BITS = 32;

endpackage

// File: rtl/pio_edge_capture_in_debounce_bit.sv
// ---------------------------------------------------------------------------
// pio_debounce_bit
//
// Purpose:
//    One board input bit: a two-flop synchronizer followed by a debouncer
//    that accepts a new level only after it has been seen for
//    DEBOUNCE_CYCLES consecutive cycles. DEBOUNCE_CYCLES = 0 bypasses the
//    debouncer, and no counter is built.
//
// Ports:
//    clk    in   system clock
//    reset  in   synchronous, active-high reset
//    din    in   asynchronous board input
//    dout   out  the level the stable register takes at the coming clock
//                edge; the top registers it, which lets it flag an edge on
//                the same edge the debounced level changes. It does not
//                account for reset, which the top applies itself.
// ---------------------------------------------------------------------------
module pio_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_LEVEL_BIT  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer. Both stages reset to the idle level so a key
    // resting at its idle level does not look like an edge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= IDLE_LEVEL_BIT;
            sync2_q <= IDLE_LEVEL_BIT;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : gBypass

            assign dout = sync2_q;

        end else begin : gCount

            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;
            logic          stable_q;
            logic          stable_d;

            // The counter measures how long the synchronized input has
            // disagreed with the accepted level. Any agreement restarts it,
            // so a glitch shorter than the window is never accepted. It
            // stops at LAST and never wraps.
            always_comb begin
                stable_d = stable_q;
                count_d  = count_q;
                if (sync2_q == stable_q) begin
                    count_d = '0;
                end else if (count_q == LAST) begin
                    stable_d = sync2_q;
                    count_d  = '0;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            // Debounce state. Reset discards any partial count and returns
            // the accepted level to idle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable_q <= IDLE_LEVEL_BIT;
                    count_q  <= '0;
                end else begin
                    stable_q <= stable_d;
                    count_q  <= count_d;
                end
            end

            assign dout = stable_d;

        end
    endgenerate

endmodule

// File: rtl/pio_edge_capture_in.sv
// ---------------------------------------------------------------------------
// pio_edge_capture_in
//
// Purpose:
//    Avalon-MM slave input PIO for the Nios SOPC. It debounces the board
//    inputs, latches the selected edges into sticky write-1-to-clear flags,
//    and raises a maskable level interrupt.
//
// Ports:
//    clk         in   system clock
//    reset       in   synchronous, active-high reset
//    address     in   register word address (0 DATA, 2 IRQMASK, 3 EDGECAPTURE)
//    chipselect  in   slave select
//    write_n     in   active-low write strobe
//    writedata   in   32-bit write data
//    readdata    out  32-bit read data, combinational from address
//    in_port     in   WIDTH asynchronous board inputs
//    irq         out  registered level interrupt
// ---------------------------------------------------------------------------
module pio_edge_capture_in
    import pio_edge_capture_in_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [PIO_BUS_BITS-1:0] writedata,
    output logic [PIO_BUS_BITS-1:0] readdata,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);

    logic [WIDTH-1:0] stableNext;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] edgeCap_q;
    logic [WIDTH-1:0] edgeCap_d;
    logic [WIDTH-1:0] irqMask_q;
    logic [WIDTH-1:0] irqMask_d;
    logic             irq_q;
    logic             irq_d;
    logic [WIDTH-1:0] setMask;
    logic [WIDTH-1:0] clearMask;
    logic             writeEn;
    logic             unusedWriteData;

    assign unusedWriteData = ^writedata;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : gBit
            pio_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .IDLE_LEVEL_BIT  (IDLE_LEVEL[g])
            ) uDebounce (
                .clk   (clk),
                .reset (reset),
                .din   (in_port[g]),
                .dout  (stableNext[g])
            );
        end
    endgenerate

    assign writeEn = chipselect & ~write_n;

    // Edge detection compares the level each debouncer is about to accept
    // with the one currently held, so a flag sets on the same edge as DATA
    // changes. Sets are ORed in after the clear, so a coincident write-1
    // loses to a new edge.
    always_comb begin
        setMask   = '0;
        clearMask = '0;
        if (EDGE_TYPE == int'(EDGE_RISING)) begin
            setMask = stableNext & ~data_q;
        end else if (EDGE_TYPE == int'(EDGE_FALLING)) begin
            setMask = ~stableNext & data_q;
        end else begin
            setMask = stableNext ^ data_q;
        end
        if (writeEn && (address == PIO_ADDR_EDGECAP)) begin
            clearMask = writedata[WIDTH-1:0];
        end
        edgeCap_d = (edgeCap_q & ~clearMask) | setMask;
    end

    // Mask register write and the interrupt term. The interrupt is taken
    // from the registered flags and mask, so it follows them by one cycle.
    always_comb begin
        irqMask_d = irqMask_q;
        if (writeEn && (address == PIO_ADDR_IRQMASK)) begin
            irqMask_d = writedata[WIDTH-1:0];
        end
        irq_d = |(edgeCap_q & irqMask_q);
    end

    // Register file state. Reset puts DATA back at the idle level together
    // with the debouncers, so reset itself never produces an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= IDLE_LEVEL;
            edgeCap_q <= '0;
            irqMask_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            data_q    <= stableNext;
            edgeCap_q <= edgeCap_d;
            irqMask_q <= irqMask_d;
            irq_q     <= irq_d;
        end
    end

    // Zero-wait-state read mux. Bits above WIDTH and the reserved word read
    // as zero.
    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:    readdata[WIDTH-1:0] = data_q;
            PIO_ADDR_RSVD:    readdata            = '0;
            PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqMask_q;
            PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edgeCap_q;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_pio_edge_capture_in.sv
// ---------------------------------------------------------------------------
// tb_pio_edge_capture_in
//
// Purpose:
//    Self-checking bench for pio_edge_capture_in with WIDTH=4,
//    DEBOUNCE_CYCLES=4 and falling-edge capture. The reference model
//    describes debouncing as a sliding window: a bit flips once its last D
//    synchronized samples all disagree with the accepted level.
// ---------------------------------------------------------------------------
module tb_pio_edge_capture_in;

    localparam int         W    = 4;
    localparam int         D    = 4;
    localparam logic [3:0] IDLE = 4'hF;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  in_port    = IDLE;
    logic        irq;

    int compareCount = 0;
    int failCount    = 0;

    logic [3:0] mStable;
    logic [3:0] mFlags;
    logic [3:0] mMask;
    logic       mIrq;
    logic [3:0] delayQ[$];
    logic [3:0] winQ[$];

    pio_edge_capture_in #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .EDGE_TYPE       (1),
        .IDLE_LEVEL      (IDLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and on disagreement counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Model state after a reset edge: idle levels everywhere, no history.
    task automatic modelReset();
        mStable = IDLE;
        mFlags  = 4'h0;
        mMask   = 4'h0;
        mIrq    = 1'b0;
        delayQ.delete();
        delayQ.push_back(IDLE);
        delayQ.push_back(IDLE);
        winQ.delete();
        for (int k = 0; k < D; k++) winQ.push_back(IDLE);
    endtask

    // Advances the model across one clock edge given the inputs at that edge.
    task automatic modelEdge(input logic rst, input logic [3:0] inV,
                             input logic wr, input logic [1:0] addr,
                             input logic [31:0] wd);
        logic [3:0] s2;
        logic [3:0] allDiff;
        logic [3:0] newStable;
        logic [3:0] fall;
        logic [3:0] clr;
        if (rst) begin
            modelReset();
        end else begin
            s2 = delayQ.pop_front();
            delayQ.push_back(inV);
            winQ.push_back(s2);
            void'(winQ.pop_front());
            allDiff = 4'hF;
            foreach (winQ[k]) allDiff &= (winQ[k] ^ mStable);
            newStable = mStable ^ allDiff;
            fall      = mStable & ~newStable;
            mIrq      = |(mFlags & mMask);
            clr       = (wr && addr == 2'd3) ? wd[3:0] : 4'h0;
            mFlags    = (mFlags & ~clr) | fall;
            if (wr && addr == 2'd2) mMask = wd[3:0];
            mStable   = newStable;
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, mStable};
            2'd2:    return {28'd0, mMask};
            2'd3:    return {28'd0, mFlags};
            default: return 32'd0;
        endcase
    endfunction

    // Drives one cycle of inputs, clocks it, and checks irq and readdata.
    task automatic applyStimulus(input logic rst, input logic [3:0] inV,
                                 input logic cs, input logic wrn,
                                 input logic [1:0] addr, input logic [31:0] wd);
        reset      = rst;
        in_port    = inV;
        chipselect = cs;
        write_n    = wrn;
        address    = addr;
        writedata  = wd;
        @(posedge clk);
        modelEdge(rst, inV, cs & ~wrn, addr, wd);
        #1;
        checkOutput("irq", {31'd0, irq}, {31'd0, mIrq});
        checkOutput($sformatf("readdata@%0d", addr), readdata, modelRead(addr));
    endtask

    task automatic idle(input logic [3:0] inV, input logic [1:0] addr);
        applyStimulus(1'b0, inV, 1'b0, 1'b1, addr, 32'd0);
    endtask

    task automatic writeReg(input logic [3:0] inV, input logic [1:0] addr,
                            input logic [31:0] wd);
        applyStimulus(1'b0, inV, 1'b1, 1'b0, addr, wd);
    endtask

    // Combinational read between clock edges.
    task automatic peek(input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    logic [31:0] rd;
    logic [3:0]  curIn;
    logic        rndRst;

    // Directed steps first, then a randomized run against the model.
    initial begin
        $display("[TB] start");
        modelReset();

        applyStimulus(1'b1, IDLE, 1'b0, 1'b1, 2'd0, 32'd0);
        applyStimulus(1'b1, IDLE, 1'b0, 1'b1, 2'd0, 32'd0);
        peek(2'd0, rd); checkOutput("rst data", rd, 32'hF);
        peek(2'd1, rd); checkOutput("rst rsvd", rd, 32'h0);
        peek(2'd2, rd); checkOutput("rst mask", rd, 32'h0);
        peek(2'd3, rd); checkOutput("rst edgecap", rd, 32'h0);
        checkOutput("rst irq", {31'd0, irq}, 32'd0);

        repeat (5) idle(4'hE, 2'd0);
        checkOutput("fall data before", readdata, 32'hF);
        idle(4'hE, 2'd0);
        checkOutput("fall data at 6", readdata, 32'hE);
        peek(2'd3, rd); checkOutput("fall edgecap", rd, 32'h1);
        idle(4'hE, 2'd0);
        checkOutput("fall irq masked", {31'd0, irq}, 32'd0);

        writeReg(4'hE, 2'd2, 32'h1);
        idle(4'hE, 2'd0);
        checkOutput("mask irq on", {31'd0, irq}, 32'd1);
        writeReg(4'hE, 2'd3, 32'h1);
        idle(4'hE, 2'd3);
        checkOutput("w1c irq off", {31'd0, irq}, 32'd0);
        checkOutput("w1c edgecap", readdata, 32'h0);

        repeat (3) idle(4'hC, 2'd0);
        repeat (8) idle(4'hE, 2'd0);
        checkOutput("glitch data", readdata, 32'hE);
        peek(2'd3, rd); checkOutput("glitch edgecap", rd, 32'h0);

        repeat (6) idle(4'hA, 2'd0);
        peek(2'd3, rd); checkOutput("bit2 edgecap", rd, 32'h4);
        repeat (6) idle(4'hE, 2'd0);
        repeat (5) idle(4'hA, 2'd0);
        writeReg(4'hA, 2'd3, 32'h4);
        checkOutput("set wins", readdata, 32'h4);
        peek(2'd0, rd); checkOutput("set wins data", rd, 32'hA);

        repeat (4) idle(4'h2, 2'd0);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b1, 2'd0, 32'd0);
        peek(2'd0, rd); checkOutput("midrst data", rd, 32'hF);
        peek(2'd3, rd); checkOutput("midrst edgecap", rd, 32'h0);
        peek(2'd2, rd); checkOutput("midrst mask", rd, 32'h0);
        repeat (5) idle(4'h2, 2'd0);
        checkOutput("reaccept before", readdata, 32'hF);
        idle(4'h2, 2'd0);
        checkOutput("reaccept at 6", readdata, 32'h2);
        peek(2'd3, rd); checkOutput("reaccept edgecap", rd, 32'hD);

        curIn = 4'h2;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) curIn = 4'($urandom);
            rndRst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0)
                applyStimulus(rndRst, curIn, 1'b1, 1'b0, 2'($urandom), $urandom);
            else
                applyStimulus(rndRst, curIn, 1'b0, 1'b1, 2'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
